// File: rtl/cypher_detector_param.sv
// Digit-serial code checker: compares strobed digits against a captured cypher,
// keeps a running sum, counts consecutive failures and locks out after MAX_FAIL.
module cypher_detector_param #(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SUM_W       = 8,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   cypher,
    input  logic [DIGIT_W-1:0]              num,
    input  logic                            read,
    input  logic                            clear,
    output logic [SUM_W-1:0]                sum,
    output logic                            right,
    output logic                            wrong,
    output logic                            locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENTRY  = 2'd1;
    localparam logic [1:0] S_RIGHT  = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic                            mismatch_q, mismatch_d;
    logic [DIGIT_W*NUM_DIGITS-1:0]   cypher_q, cypher_d;
    logic [LW-1:0]                   lock_cnt_q, lock_cnt_d;
    logic [SUM_W-1:0]                sum_q, sum_d;
    logic                            right_q, right_d;
    logic                            wrong_q, wrong_d;
    logic                            locked_q, locked_d;
    logic [FW-1:0]                   fail_q, fail_d;
    logic [FW-1:0]                   fail_inc;
    logic [DIGIT_W-1:0]              digit_k;
    logic                            digit_ne;

    // Digit 0 lives in the most-significant slice of the captured cypher.
    always_comb begin
        digit_k = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit_k = cypher_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_ne = (num != digit_k);
    assign fail_inc = fail_q + FW'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        cypher_d   = cypher_q;
        lock_cnt_d = lock_cnt_q;
        sum_d      = sum_q;
        right_d    = right_q;
        wrong_d    = 1'b0;
        locked_d   = locked_q;
        fail_d     = fail_q;

        case (state_q)
            S_IDLE, S_RIGHT: begin
                if (clear) begin
                    state_d = S_IDLE;
                    right_d = 1'b0;
                end else if (read) begin
                    cypher_d   = cypher;
                    sum_d      = SUM_W'(num);
                    idx_d      = IW'(1);
                    mismatch_d = (num != cypher[DIGIT_W*NUM_DIGITS-1 -: DIGIT_W]);
                    right_d    = 1'b0;
                    state_d    = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear) begin
                    state_d    = S_IDLE;
                    sum_d      = '0;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                end else if (read) begin
                    sum_d = sum_q + SUM_W'(num);
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!(mismatch_q || digit_ne)) begin
                            state_d = S_RIGHT;
                            right_d = 1'b1;
                            fail_d  = '0;
                        end else begin
                            wrong_d = 1'b1;
                            fail_d  = fail_inc;
                            if (fail_inc == FW'(MAX_FAIL)) begin
                                state_d    = S_LOCKED;
                                locked_d   = 1'b1;
                                lock_cnt_d = LW'(LOCK_CYCLES - 1);
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        idx_d      = idx_q + IW'(1);
                        mismatch_d = mismatch_q | digit_ne;
                    end
                end
            end
            S_LOCKED: begin
                // Counter is loaded with LOCK_CYCLES-1 so locked spans exactly LOCK_CYCLES cycles.
                if (lock_cnt_q == '0) begin
                    state_d  = S_IDLE;
                    locked_d = 1'b0;
                    fail_d   = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            cypher_q   <= '0;
            lock_cnt_q <= '0;
            sum_q      <= '0;
            right_q    <= 1'b0;
            wrong_q    <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            cypher_q   <= cypher_d;
            lock_cnt_q <= lock_cnt_d;
            sum_q      <= sum_d;
            right_q    <= right_d;
            wrong_q    <= wrong_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
        end
    end

    assign sum        = sum_q;
    assign right      = right_q;
    assign wrong      = wrong_q;
    assign locked     = locked_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_cypher_detector_param.sv
// Directed bench for cypher_detector_param: default instance plus a SUM_W=4 instance
// for sum wrap-around.
module tb_cypher_detector_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cypher0 = 16'h1234;
    logic [3:0]  num0 = '0;
    logic        read0 = 1'b0;
    logic        clear0 = 1'b0;
    logic [7:0]  sum0;
    logic        right0, wrong0, locked0;
    logic [1:0]  fail0;

    logic [15:0] cypher1 = 16'hFFFF;
    logic [3:0]  num1 = '0;
    logic        read1 = 1'b0;
    logic        clear1 = 1'b0;
    logic [3:0]  sum1;
    logic        right1, wrong1, locked1;
    logic [1:0]  fail1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cypher_detector_param dut0 (
        .clock(clock), .reset(reset), .cypher(cypher0), .num(num0),
        .read(read0), .clear(clear0), .sum(sum0), .right(right0),
        .wrong(wrong0), .locked(locked0), .fail_count(fail0)
    );

    cypher_detector_param #(.SUM_W(4)) dut1 (
        .clock(clock), .reset(reset), .cypher(cypher1), .num(num1),
        .read(read1), .clear(clear1), .sum(sum1), .right(right1),
        .wrong(wrong1), .locked(locked1), .fail_count(fail1)
    );

    typedef struct {
        logic        rd;
        logic        clr;
        logic [3:0]  n;
        logic [15:0] cy;
        logic [12:0] exp;   // {sum, right, wrong, locked, fail_count}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] pk(input logic [7:0] s, input logic r, input logic w,
                                       input logic l, input logic [1:0] f);
        return {s, r, w, l, f};
    endfunction

    task automatic add(input logic rd, input logic clr, input logic [3:0] n, input logic [15:0] cy,
                       input logic [7:0] s, input logic r, input logic w, input logic l,
                       input logic [1:0] f);
        vec_t v;
        v.rd = rd; v.clr = clr; v.n = n; v.cy = cy; v.exp = pk(s, r, w, l, f);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {sum,r,w,l,f}=%h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step0(input logic rd, input logic clr, input logic [3:0] n, input logic [15:0] cy);
        @(negedge clock);
        read0 = rd; clear0 = clr; num0 = n; cypher0 = cy;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [12:0] act0();
        return {sum0, right0, wrong0, locked0, fail0};
    endfunction

    function automatic logic [12:0] act1();
        return {4'h0, sum1, right1, wrong1, locked1, fail1};
    endfunction

    initial begin
        int hi;

        // A: correct code, hold, clear acknowledges but keeps sum
        add(1,0,4'd1,16'h1234, 8'd1, 0,0,0,2'd0);
        add(1,0,4'd2,16'h1234, 8'd3, 0,0,0,2'd0);
        add(1,0,4'd3,16'h1234, 8'd6, 0,0,0,2'd0);
        add(1,0,4'd4,16'h1234, 8'd10,1,0,0,2'd0);
        add(0,0,4'd0,16'h1234, 8'd10,1,0,0,2'd0);
        add(0,1,4'd0,16'h1234, 8'd10,0,0,0,2'd0);
        // B: last digit wrong -> one-cycle wrong pulse
        add(1,0,4'd1,16'h1234, 8'd1, 0,0,0,2'd0);
        add(1,0,4'd2,16'h1234, 8'd3, 0,0,0,2'd0);
        add(1,0,4'd3,16'h1234, 8'd6, 0,0,0,2'd0);
        add(1,0,4'd5,16'h1234, 8'd11,0,1,0,2'd1);
        add(0,0,4'd0,16'h1234, 8'd11,0,0,0,2'd1);
        // C: clear with read mid-entry aborts without counting, then success resets count
        add(1,0,4'd1,16'h1234, 8'd1, 0,0,0,2'd1);
        add(1,0,4'd2,16'h1234, 8'd3, 0,0,0,2'd1);
        add(1,1,4'd3,16'h1234, 8'd0, 0,0,0,2'd1);
        add(1,0,4'd1,16'h1234, 8'd1, 0,0,0,2'd1);
        add(1,0,4'd2,16'h1234, 8'd3, 0,0,0,2'd1);
        add(1,0,4'd3,16'h1234, 8'd6, 0,0,0,2'd1);
        add(1,0,4'd4,16'h1234, 8'd10,1,0,0,2'd0);
        // D: new attempt from RIGHT, cypher changes mid-entry
        add(1,0,4'd1,16'h1234, 8'd1, 0,0,0,2'd0);
        add(1,0,4'd2,16'h9999, 8'd3, 0,0,0,2'd0);
        add(1,0,4'd3,16'h9999, 8'd6, 0,0,0,2'd0);
        add(1,0,4'd4,16'h9999, 8'd10,1,0,0,2'd0);
        // E: mismatch only on digit 0
        add(1,0,4'd5,16'h1234, 8'd5, 0,0,0,2'd0);
        add(1,0,4'd2,16'h1234, 8'd7, 0,0,0,2'd0);
        add(1,0,4'd3,16'h1234, 8'd10,0,0,0,2'd0);
        add(1,0,4'd4,16'h1234, 8'd14,0,1,0,2'd1);
        add(0,0,4'd0,16'h1234, 8'd14,0,0,0,2'd1);

        #2;
        chk("reset0", act0(), pk(8'd0,0,0,0,2'd0));
        chk("reset1", act1(), pk(8'd0,0,0,0,2'd0));
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step0(vecs[i].rd, vecs[i].clr, vecs[i].n, vecs[i].cy);
            chk($sformatf("vec%0d", i), act0(), vecs[i].exp);
        end

        // Two more failures (count is 1) reach MAX_FAIL and lock
        for (int a = 0; a < 2; a++) begin
            step0(1, 0, 4'd1, 16'h1234);
            step0(1, 0, 4'd2, 16'h1234);
            step0(1, 0, 4'd3, 16'h1234);
            step0(1, 0, 4'd5, 16'h1234);
            chk($sformatf("fail_att%0d", a), act0(),
                pk(8'd11, 0, 1, (a == 1), 2'(a + 2)));
        end

        hi = 1;
        for (int c = 0; c < 40; c++) begin
            step0(1, c[0], 4'd7, 16'h1234);
            if (c == 0) chk("lock_wrong_pulse", act0(), pk(8'd11,0,0,1,2'd3));
            if (!locked0) break;
            hi++;
            chk_int("lock_sum_hold", int'(sum0), 11);
        end
        chk_int("lock_len", hi, 16);
        chk("unlock", act0(), pk(8'd11,0,0,0,2'd0));

        step0(1, 0, 4'd1, 16'h1234);
        chk("post_lock_d0", act0(), pk(8'd1,0,0,0,2'd0));
        step0(1, 0, 4'd2, 16'h1234);
        step0(1, 0, 4'd3, 16'h1234);
        step0(1, 0, 4'd4, 16'h1234);
        chk("post_lock_right", act0(), pk(8'd10,1,0,0,2'd0));

        // Asynchronous reset mid-entry with a nonzero failure count
        step0(1, 0, 4'd1, 16'h1234);
        step0(1, 0, 4'd2, 16'h1234);
        step0(1, 0, 4'd3, 16'h1234);
        step0(1, 0, 4'd5, 16'h1234);
        step0(1, 0, 4'd1, 16'h1234);
        step0(1, 0, 4'd2, 16'h1234);
        chk("pre_reset", act0(), pk(8'd3,0,0,0,2'd1));
        @(negedge clock);
        read0 = 1'b0;
        reset = 1'b1;
        #2;
        chk("async_reset", act0(), pk(8'd0,0,0,0,2'd0));
        #1;
        reset = 1'b0;
        step0(1, 0, 4'd1, 16'h1234);
        step0(1, 0, 4'd2, 16'h1234);
        step0(1, 0, 4'd3, 16'h1234);
        step0(1, 0, 4'd4, 16'h1234);
        chk("after_reset_right", act0(), pk(8'd10,1,0,0,2'd0));
        step0(0, 0, 4'd0, 16'h1234);

        // SUM_W=4 wrap-around: F,F,F,F -> 15,14,13,12
        for (int d = 0; d < 4; d++) begin
            @(negedge clock);
            read1 = 1'b1; num1 = 4'hF;
            @(posedge clock);
            #1;
            chk($sformatf("wrap_d%0d", d), act1(),
                pk(8'(15 - d), (d == 3), 0, 0, 2'd0));
        end
        @(negedge clock);
        read1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

endmodule

// File: doc/cypher_detector_param.md
# cypher_detector_param

Parametrised successor to the team's fixed 16-bit cypher detector. Accepts a code one digit at a time on `read` strobes, compares the digits in order against a `NUM_DIGITS`-digit cypher, and reports a running digit sum. It adds behaviour the fixed block lacks: explicit failure indication, a failure counter, a timed lockout after repeated failures, and an abort input. It sits between the keypad/digit-entry front end and the unlock/status logic.

## Interface
- `DIGIT_W`, 4: bits per digit.
- `NUM_DIGITS`, 4: digits per code (≥2).
- `SUM_W`, 8: width of the running sum.
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout (≥1).
- `LOCK_CYCLES`, 16: lockout duration in clock cycles (≥1).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cypher`  in  DIGIT_W*NUM_DIGITS  reference code; digit 0 is the most-significant DIGIT_W slice.
- `num`  in  DIGIT_W  entered digit, valid when `read`=1.
- `read`  in  1  single-cycle digit strobe.
- `clear`  in  1  abort current entry / acknowledge success.
- `sum`  out  SUM_W  running sum of digits in the current or last attempt.
- `right`  out  1  code accepted; level.
- `wrong`  out  1  code rejected; one-cycle pulse.
- `locked`  out  1  lockout active.
- `fail_count`  out  clog2(MAX_FAIL+1)  consecutive failures.

## Operation
- States: IDLE, ENTRY, RIGHT, LOCKED. Internal: digit index (0..NUM_DIGITS-1), mismatch flag, captured cypher, lock counter.
- Reset: state IDLE; `sum`=0, `right`=0, `wrong`=0, `locked`=0, `fail_count`=0, index 0, mismatch 0.
- IDLE or RIGHT, `read`=1: start an attempt. Capture `cypher`. `sum` <= zero-extended `num`. Index <= 1. Mismatch <= (`num` != digit 0). `right` <= 0. Next state ENTRY.
- ENTRY, `read`=1 on digit k: `sum` <= `sum` + `num`, modulo 2^SUM_W. OR (`num` != captured digit k) into mismatch. Increment index.
- Final digit (k = NUM_DIGITS-1), match over all digits:
  - Next state RIGHT; `right` <= 1; `fail_count` <= 0.
- Final digit, any mismatch:
  - `wrong` pulses; `fail_count` += 1.
  - If the new count equals MAX_FAIL: next state LOCKED, `locked` <= 1, lock counter loaded.
  - Otherwise: next state IDLE.
- A change on `cypher` during ENTRY is ignored; the captured copy is used.
- `clear` in ENTRY: next state IDLE, `sum` <= 0, index 0. No failure is counted.
- `clear` in RIGHT: next state IDLE, `right` <= 0, `sum` held.
- `clear` in IDLE or LOCKED: no effect.
- `clear` and `read` in the same cycle: `clear` wins and the digit is discarded.
- LOCKED: `read` and `clear` are ignored, and `sum` holds. After LOCK_CYCLES cycles: next state IDLE, `locked` <= 0, `fail_count` <= 0.
- `sum` holds its value in IDLE until the next attempt's first digit.

## Timing
- All outputs are registered and update on the `clock` rising edge that samples the causing input.
- `right`, the `wrong` pulse, and `locked` all become visible after the edge that samples the final digit (zero added latency).
- `wrong` is high for exactly one cycle per failed attempt.
- `locked` is high for exactly LOCK_CYCLES cycles. A `read` on the cycle after `locked` falls is accepted.
- Back-to-back `read` on consecutive cycles is supported; every strobe is one digit.
- `reset` asynchronously forces all state and outputs to their reset values, including mid-entry and mid-lockout.

## Test plan
- Defaults, `cypher`=16'h1234, digits 1,2,3,4 -> after the 4th edge `right`=1, `sum`=10, `fail_count`=0. Then `clear` -> `right`=0, `sum` stays 10.
- Digits 1,2,3,5 -> one-cycle `wrong` pulse, `sum`=11, `fail_count`=1, `right`=0, state IDLE.
- Three wrong attempts -> `locked`=1 for exactly 16 cycles. Reads during lockout leave `sum` unchanged. Then `locked`=0 and `fail_count`=0, and 1,2,3,4 yields `right`=1.
- Digits 1,2, then `clear` together with `read` of 3 -> `sum`=0 and `fail_count` unchanged. Then 1,2,3,4 -> `right`=1.
- `cypher` changed to 16'h9999 after the first digit, then 1,2,3,4 entered -> `right`=1. `reset` pulsed after 2 digits -> all outputs 0 with no clock edge needed.
- `SUM_W`=4, `cypher`=16'hFFFF, digits F,F,F,F -> `sum`=12 (60 mod 16), `right`=1.
